// File: rtl/stage_counter.sv
// Purpose: free-running instruction stage sequencer for the multi-cycle CPU control path (0 idle, then 1..LAST repeating).
// Latency: out is a bare flop; reads 1 one rising edge after reset release and LAST after LAST edges.
// Backpressure: none; the count advances on every clock edge while out of reset, with no stall input.
module stage_counter #(
   parameter int WIDTH = 3,
   parameter int LAST  = 5
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   localparam logic [WIDTH-1:0] STAGE_FIRST = WIDTH'(1);
   localparam logic [WIDTH-1:0] STAGE_LAST  = WIDTH'(LAST);

   // Idle (0), the last stage and any corrupt value above LAST all restart at stage 1.
   logic restart;
   assign restart = (out == '0) || (out >= STAGE_LAST);

   // Stage register: async clear to idle, otherwise step or wrap on every edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out <= '0;
      end else if (restart) begin
         out <= STAGE_FIRST;
      end else begin
         out <= out + STAGE_FIRST;
      end
   end

endmodule

// File: tb/tb_stage_counter.sv
// Bench for stage_counter: default instance (WIDTH=3, LAST=5) and a WIDTH=4, LAST=9 variant.
// Expected stage values are queued when each edge is launched and popped once the edge has settled.
// Reset changes are driven on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_stage_counter;

   logic       clk;
   logic       rst0;
   logic       rst1;
   logic [2:0] out0;
   logic [3:0] out1;

   int checks;
   int errors;

   logic [3:0] sb_q[$];

   typedef struct {
      logic       rst;
      logic [3:0] exp;
   } vec_t;

   vec_t vecs[15];

   stage_counter #(.WIDTH(3), .LAST(5)) stage (
      .clk   (clk),
      .reset (rst0),
      .out   (out0)
   );

   stage_counter #(.WIDTH(4), .LAST(9)) stage_w4 (
      .clk   (clk),
      .reset (rst1),
      .out   (out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Queue the expectation, take one rising edge, then pop and compare against the chosen instance.
   task automatic edge_check(input string name, input logic [3:0] exp, input bit variant);
      logic [3:0] e;
      logic [3:0] a;
      sb_q.push_back(exp);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      a = variant ? out1 : {1'b0, out0};
      check(name, a, e);
   endtask

   initial begin
      int hist[8];
      int illegal;
      checks  = 0;
      errors  = 0;
      illegal = 0;
      rst0    = 1'b0;
      rst1    = 1'b0;

      // Reset for 3 edges, then 12 free-running edges.
      vecs[0]  = '{1'b0, 4'd0};
      vecs[1]  = '{1'b0, 4'd0};
      vecs[2]  = '{1'b0, 4'd0};
      vecs[3]  = '{1'b1, 4'd1};
      vecs[4]  = '{1'b1, 4'd2};
      vecs[5]  = '{1'b1, 4'd3};
      vecs[6]  = '{1'b1, 4'd4};
      vecs[7]  = '{1'b1, 4'd5};
      vecs[8]  = '{1'b1, 4'd1};
      vecs[9]  = '{1'b1, 4'd2};
      vecs[10] = '{1'b1, 4'd3};
      vecs[11] = '{1'b1, 4'd4};
      vecs[12] = '{1'b1, 4'd5};
      vecs[13] = '{1'b1, 4'd1};
      vecs[14] = '{1'b1, 4'd2};

      #1;
      check("reset_value", {1'b0, out0}, 4'd0);
      check("reset_value_w4", out1, 4'd0);

      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         rst0 = vecs[i].rst;
         edge_check($sformatf("vec%0d", i), vecs[i].exp, 1'b0);
      end

      // Asynchronous assert while in stage 3.
      edge_check("to_stage3", 4'd3, 1'b0);
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      check("async_assert", {1'b0, out0}, 4'd0);
      edge_check("hold_reset_a", 4'd0, 1'b0);
      edge_check("hold_reset_b", 4'd0, 1'b0);

      // Mid-sequence restart from stage 5.
      @(negedge clk);
      rst0 = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         edge_check($sformatf("run_to5_%0d", i), 4'(i), 1'b0);
      end
      @(negedge clk);
      rst0 = 1'b0;
      #1;
      check("async_assert_s5", {1'b0, out0}, 4'd0);
      @(negedge clk);
      rst0 = 1'b1;
      edge_check("restart_after_s5", 4'd1, 1'b0);

      // Wrap check: 100 edges from a fresh reset.
      @(negedge clk);
      rst0 = 1'b0;
      @(negedge clk);
      rst0 = 1'b1;
      for (int k = 0; k < 8; k++) hist[k] = 0;
      for (int i = 0; i < 100; i++) begin
         edge_check($sformatf("wrap%0d", i), 4'((i % 5) + 1), 1'b0);
         hist[out0]++;
         if (out0 == 3'd0 || out0 == 3'd6 || out0 == 3'd7) illegal++;
      end
      check("wrap_illegal_count", 4'(illegal), 4'd0);
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if (hist[k] != 20) begin
            errors++;
            $display("FAIL wrap_hist_%0d: got %0d, expected 20", k, hist[k]);
         end
      end

      // Illegal-state recovery from 7 and from 6.
      @(negedge clk);
      force stage.out = 3'd7;
      #1;
      release stage.out;
      edge_check("recover_from_7", 4'd1, 1'b0);
      @(negedge clk);
      force stage.out = 3'd6;
      #1;
      release stage.out;
      edge_check("recover_from_6", 4'd1, 1'b0);
      edge_check("after_recover", 4'd2, 1'b0);

      // Variant WIDTH=4, LAST=9.
      check("w4_reset_hold", out1, 4'd0);
      @(negedge clk);
      rst1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         edge_check($sformatf("w4_seq%0d", i), 4'((i % 9) + 1), 1'b1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
